// File: rtl/serial_rx_if.sv
// Handshake and data bundle between the serial receiver and its user.
// master: the side that arms captures, owns the line and the timebase.
// slave: the receiver itself.
interface serial_rx_if;
  logic         start;
  logic         abort;
  logic         din;
  logic [7:0]   nbits;
  logic [31:0]  n0;
  logic [31:0]  n1;
  logic [31:0]  ns;
  logic [31:0]  cnt;
  logic [255:0] data;
  logic         valid;
  logic         busy;

  modport master (
    output start, abort, din, nbits, n0, n1, ns, cnt,
    input  data, valid, busy
  );

  modport slave (
    input  start, abort, din, nbits, n0, n1, ns, cnt,
    output data, valid, busy
  );
endinterface

// File: rtl/serial_rx.sv
// Serial receiver. The line is sampled MSB first at absolute instants of the
// shared cnt timebase: sample k lands at cnt == n0 + ns + k*n1 (mod 2^32).
// The rx stays phase-locked to serial_tx without any clock recovery.
module serial_rx #(
  parameter int P_SYNC = 2  // din synchronizer depth, 0..3
) (
  input  logic        clk,
  input  logic        rst,
  serial_rx_if.slave  bus
);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t       state, state_nx;
  logic         din_s;
  logic [7:0]   nbits_i;
  logic [7:0]   bit_cnt;
  logic [31:0]  n1_i;
  logic [31:0]  next_sample;
  logic [255:0] sr;
  logic [255:0] data_q;
  logic         valid_q;
  logic         accept;
  logic         hit;
  logic         last;

  // Zero on any framing input means "one".
  logic [7:0]   nbits_eff;
  logic [31:0]  n0_eff, n1_eff, ns_eff;
  assign nbits_eff = (bus.nbits == 8'd0) ? 8'd1  : bus.nbits;
  assign n0_eff    = (bus.n0 == 32'd0)   ? 32'd1 : bus.n0;
  assign n1_eff    = (bus.n1 == 32'd0)   ? 32'd1 : bus.n1;
  assign ns_eff    = (bus.ns == 32'd0)   ? 32'd1 : bus.ns;

  // Optional synchronizer chain; its delay is compensated by the user via ns.
  generate
    if (P_SYNC == 0) begin : g_nosync
      assign din_s = bus.din;
    end else begin : g_sync
      logic [P_SYNC-1:0] sync_q;
      // Shift the raw line through P_SYNC flops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= P_SYNC'({sync_q, bus.din});
      end
      assign din_s = sync_q[P_SYNC-1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-cycle control strobes; abort beats start and a
  // coincident last sample.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    hit      = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          accept   = 1'b1;
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (bus.cnt == next_sample) begin
          hit = 1'b1;
          if (bit_cnt == nbits_i - 8'd1) begin
            last     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame parameters latched at start, shift/sample bookkeeping, output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nbits_i     <= 8'd0;
      n1_i        <= 32'd0;
      next_sample <= 32'd0;
      bit_cnt     <= 8'd0;
      sr          <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        nbits_i     <= nbits_eff;
        n1_i        <= n1_eff;
        next_sample <= n0_eff + ns_eff;
        bit_cnt     <= 8'd0;
        sr          <= '0;
      end else if (hit) begin
        sr          <= {sr[254:0], din_s};
        bit_cnt     <= bit_cnt + 8'd1;
        next_sample <= next_sample + n1_i;
        if (last) begin
          data_q  <= {sr[254:0], din_s};
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state == ARMED);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: a behavioural serial_tx line model driven from the
// timebase, a table of frames, a scoreboard of expected words, and hand-made
// sequences for abort, reset mid-frame and start-while-armed.
module tb_serial_rx;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst;
  serial_rx_if bus();

  serial_rx #(.P_SYNC(P)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  logic [255:0] q[$];
  logic [255:0] last_word = '0;

  // Transmitter model state: bit k occupies cnt in [n0+k*n1, n0+(k+1)*n1).
  logic [255:0] tx_word;
  logic [7:0]   tx_nb;
  logic [31:0]  tx_n0, tx_n1;
  logic         tx_idle;

  function automatic logic line_bit(input logic [31:0] c, input logic [255:0] w,
                                    input logic [7:0] nb, input logic [31:0] b0,
                                    input logic [31:0] bp, input logic idle);
    logic [31:0] k;
    k = (c - b0) / bp;
    if (k < 32'(nb)) return w[nb - 8'd1 - k[7:0]];
    return idle;
  endfunction

  assign bus.din = line_bit(bus.cnt, tx_word, tx_nb, tx_n0, tx_n1, tx_idle);

  // Free-running timebase; the bench may jump it with cnt_load.
  logic        cnt_load;
  logic [31:0] cnt_val;
  always @(posedge clk) bus.cnt <= cnt_load ? cnt_val : bus.cnt + 32'd1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.valid === 1'b1) begin
      n_valid++;
      chk("busy_low_with_valid", {255'd0, bus.busy}, 256'd0);
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got data %0h expected no valid", bus.data);
      end else begin
        logic [255:0] e;
        e = q.pop_front();
        if (bus.data !== e) begin
          fails++;
          $display("FAIL sb_data: got %0h expected %0h", bus.data, e);
        end
        last_word = e;
      end
    end
  end

  task automatic wait_sb(input int lim);
    int c;
    c = 0;
    while (q.size() != 0 && c < lim) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_timeout: got %0d words pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_cnt(input logic [31:0] target, input int lim);
    int c;
    c = 0;
    while (bus.cnt !== target && c < lim) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (bus.cnt !== target) begin
      fails++;
      $display("FAIL cnt_timeout: got %0h expected %0h", bus.cnt, target);
    end
  endtask

  // Program tx model + DUT inputs, jump cnt to n0-5, pulse start.
  task automatic arm(input logic [255:0] w, input logic [7:0] nb, input logic [31:0] b0,
                     input logic [31:0] bp, input logic [31:0] s, input logic idle);
    @(negedge clk);
    tx_word = w;
    tx_nb   = (nb == 8'd0) ? 8'd1 : nb;
    tx_n0   = (b0 == 32'd0) ? 32'd1 : b0;
    tx_n1   = (bp == 32'd0) ? 32'd1 : bp;
    tx_idle = idle;
    bus.nbits = nb; bus.n0 = b0; bus.n1 = bp; bus.ns = s;
    cnt_load = 1'b1;
    cnt_val  = tx_n0 - 32'd5;
    @(negedge clk);
    cnt_load  = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", {255'd0, bus.busy}, {255'd0, 1'b1});
  endtask

  typedef struct {
    logic [255:0] word;
    logic [7:0]   nbits;
    logic [31:0]  n0, n1, ns;
    logic         idle;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nv;
    vecs[0] = '{256'hA5,       8'd8,   32'd10,         32'd4, 32'(2 + P), 1'b0, 256'hA5};
    vecs[1] = '{256'h1,        8'd1,   32'd1,          32'd1, 32'(P),     1'b0, 256'h1};
    vecs[2] = '{256'h1,        8'd0,   32'd0,          32'd0, 32'd0,      1'b1, 256'h1};
    vecs[3] = '{256'h3C,       8'd8,   32'hFFFF_FFF0,  32'd8, 32'(3 + P), 1'b0, 256'h3C};
    vecs[4] = '{256'hABC,      8'd12,  32'd100,        32'd3, 32'(1 + P), 1'b0, 256'hABC};
    vecs[5] = '{256'hDEADBEEF, 8'd32,  32'd50,         32'd2, 32'(1 + P), 1'b0, 256'hDEADBEEF};
    vecs[6] = '{256'hB4,       8'd8,   32'd40,         32'd2, 32'(3 + P), 1'b0, 256'h68};
    vecs[7] = '{{256{1'b1}},   8'd255, 32'd20,         32'd1, 32'(P),     1'b0, {1'b0, {255{1'b1}}}};

    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.nbits = 8'd0; bus.n0 = 32'd0; bus.n1 = 32'd0; bus.ns = 32'd0;
    cnt_load = 1'b1; cnt_val = 32'd0;
    tx_word = '0; tx_nb = 8'd1; tx_n0 = 32'd1; tx_n1 = 32'd1; tx_idle = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data",  bus.data, 256'd0);
    chk("reset_valid", {255'd0, bus.valid}, 256'd0);
    chk("reset_busy",  {255'd0, bus.busy}, 256'd0);
    rst = 1'b0;

    // Table of complete frames.
    for (int i = 0; i < 8; i++) begin
      q.push_back(vecs[i].exp);
      arm(vecs[i].word, vecs[i].nbits, vecs[i].n0, vecs[i].n1, vecs[i].ns, vecs[i].idle);
      wait_sb(2000);
      @(negedge clk);
      chk("busy_after_frame", {255'd0, bus.busy}, 256'd0);
    end

    // start with abort in IDLE: abort wins, nothing armed.
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_idle", {255'd0, bus.busy}, 256'd0);

    // Abort after the 5th of 16 samples (samples at 104,108,...,120).
    nv = n_valid;
    arm(256'h1234, 8'd16, 32'd100, 32'd4, 32'(2 + P), 1'b0);
    wait_cnt(32'd121, 200);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", {255'd0, bus.busy}, 256'd0);
    repeat (100) @(negedge clk);
    chk("abort_no_valid", 256'(n_valid), 256'(nv));
    chk("abort_data_kept", bus.data, last_word);

    // Abort coincident with the last sample (cnt 316).
    arm(256'h9, 8'd4, 32'd300, 32'd4, 32'(2 + P), 1'b0);
    wait_cnt(32'd316, 200);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_last_busy", {255'd0, bus.busy}, 256'd0);
    repeat (20) @(negedge clk);
    chk("abort_last_no_valid", 256'(n_valid), 256'(nv));
    chk("abort_last_data", bus.data, last_word);

    // Reset mid-frame: outputs return to reset values immediately.
    arm(256'hC3, 8'd8, 32'd400, 32'd4, 32'(2 + P), 1'b0);
    wait_cnt(32'd415, 200);
    rst = 1'b1;
    #1;
    chk("rst_mid_data",  bus.data, 256'd0);
    chk("rst_mid_valid", {255'd0, bus.valid}, 256'd0);
    chk("rst_mid_busy",  {255'd0, bus.busy}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_no_valid", 256'(n_valid), 256'(nv));

    // New frame after reset, with stray starts while armed.
    q.push_back(256'h5A);
    arm(256'h5A, 8'd8, 32'd500, 32'd4, 32'(2 + P), 1'b0);
    repeat (3) begin
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.nbits = 8'd4; bus.n0 = 32'd900;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_sb(500);
    chk("second_frame_count", 256'(n_valid), 256'(nv + 1));
    chk("second_frame_data", bus.data, 256'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
